// File: rtl/mm_pkg.sv
// Shared constants and types for the 3x3 matrix-engine arbiter.
// The operand packing is row-major, with element k held in bits [k*INT_WIDTH +: INT_WIDTH].
package mm_pkg;

    localparam int INT_WIDTH = 8;
    localparam int MAT_ELEMS = 9;
    localparam int MAT_BITS  = MAT_ELEMS * INT_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_RESP    = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_RECOVER = 3'd4
    } mm_state_e;

    function automatic logic [INT_WIDTH-1:0] mm_elem(input logic [MAT_BITS-1:0] m, input int k);
        return m[k*INT_WIDTH +: INT_WIDTH];
    endfunction

endpackage

// File: rtl/mm_rr_pick.sv
// Two-way round-robin picker.
// The requester named by i_ptr has priority; the other requester wins only when it is the sole requester.
module mm_rr_pick (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_win
);

    // one-hot winner selection
    always_comb begin
        o_win = 2'b00;
        if (i_ptr == 1'b0) begin
            if (i_req[0]) begin
                o_win = 2'b01;
            end else if (i_req[1]) begin
                o_win = 2'b10;
            end else begin
                o_win = 2'b00;
            end
        end else begin
            if (i_req[1]) begin
                o_win = 2'b10;
            end else if (i_req[0]) begin
                o_win = 2'b01;
            end else begin
                o_win = 2'b00;
            end
        end
    end

endmodule

// File: rtl/mm_engine_arbiter.sv
// Arbitrates two requesters onto a single 3x3 matrix engine.
// It handles completion, timeout, abort, drain and engine-reset recovery.
module mm_engine_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int INT_WIDTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               req,
    input  logic [9*INT_WIDTH-1:0]   a0,
    input  logic [9*INT_WIDTH-1:0]   b0,
    input  logic [9*INT_WIDTH-1:0]   a1,
    input  logic [9*INT_WIDTH-1:0]   b1,
    output logic [1:0]               gnt,
    output logic [1:0]               ack,
    output logic [1:0]               err,
    output logic [9*INT_WIDTH-1:0]   c_out,
    output logic                     eng_en,
    output logic [9*INT_WIDTH-1:0]   eng_a,
    output logic [9*INT_WIDTH-1:0]   eng_b,
    input  logic [9*INT_WIDTH-1:0]   eng_c,
    input  logic                     eng_done,
    output logic                     eng_rst
);

    import mm_pkg::*;

    localparam int W_MAT = MAT_ELEMS * INT_WIDTH;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    mm_state_e          r_state;
    logic               r_ptr;
    logic               r_g;
    logic [1:0]         r_gnt;
    logic [1:0]         r_ack;
    logic [1:0]         r_err;
    logic [W_MAT-1:0]   r_c_out;
    logic               r_eng_en;
    logic [W_MAT-1:0]   r_eng_a;
    logic [W_MAT-1:0]   r_eng_b;
    logic               r_eng_rst;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rec_cnt;
    logic [1:0]         w_win;
    logic               w_timeout;

    mm_rr_pick u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_win (w_win)
    );

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // job-control FSM; ack/err default low so they pulse exactly one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 1'b0;
            r_g       <= 1'b0;
            r_gnt     <= 2'b00;
            r_ack     <= 2'b00;
            r_err     <= 2'b00;
            r_c_out   <= {W_MAT{1'b0}};
            r_eng_en  <= 1'b0;
            r_eng_a   <= {W_MAT{1'b0}};
            r_eng_b   <= {W_MAT{1'b0}};
            r_eng_rst <= 1'b0;
            r_cnt     <= {CNT_W{1'b0}};
            r_rec_cnt <= 1'b0;
        end else begin
            r_ack <= 2'b00;
            r_err <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (w_win != 2'b00) begin
                        r_state  <= ST_RUN;
                        r_gnt    <= w_win;
                        r_g      <= w_win[1];
                        r_eng_en <= 1'b1;
                        r_eng_a  <= w_win[1] ? a1 : a0;
                        r_eng_b  <= w_win[1] ? b1 : b0;
                        r_cnt    <= {CNT_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    // a withdrawn request aborts silently; completion beats a same-cycle timeout
                    if (!req[r_g]) begin
                        r_state   <= ST_RECOVER;
                        r_gnt     <= 2'b00;
                        r_eng_en  <= 1'b0;
                        r_eng_rst <= 1'b1;
                        r_rec_cnt <= 1'b0;
                        r_ptr     <= ~r_g;
                    end else if (eng_done) begin
                        r_state  <= ST_RESP;
                        r_c_out  <= eng_c;
                        r_ack    <= r_gnt;
                        r_gnt    <= 2'b00;
                        r_eng_en <= 1'b0;
                    end else if (w_timeout) begin
                        r_state   <= ST_RECOVER;
                        r_err     <= r_gnt;
                        r_gnt     <= 2'b00;
                        r_eng_en  <= 1'b0;
                        r_eng_rst <= 1'b1;
                        r_rec_cnt <= 1'b0;
                        r_ptr     <= ~r_g;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    r_ptr   <= ~r_g;
                    r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!eng_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RECOVER: begin
                    if (r_rec_cnt) begin
                        r_eng_rst <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_rec_cnt <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_gnt     <= 2'b00;
                    r_eng_en  <= 1'b0;
                    r_eng_rst <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign ack     = r_ack;
    assign err     = r_err;
    assign c_out   = r_c_out;
    assign eng_en  = r_eng_en;
    assign eng_a   = r_eng_a;
    assign eng_b   = r_eng_b;
    // the engine is held in reset for as long as the arbiter itself is in reset
    assign eng_rst = r_eng_rst | ~rst_n;

endmodule
